// File: rtl/interrupt_controller_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_controller_pkg
// Shared definitions for the interrupt controller slice.
//   state_e          : controller state encoding (IDLE / REQ / SERVICE)
//   DEFAULT_DBITS    : default width of the device number output
//   DEFAULT_IDN_BASE : default device number reported for source 0
//   idx_width()      : width of a binary source index for n sources
// Optional feature macro used by the importing modules: INTC_ROUND_ROBIN_EN
// ---------------------------------------------------------------------------
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_e;

    localparam int DEFAULT_DBITS    = 32;
    localparam int DEFAULT_IDN_BASE = 0;

    // A single source still needs a one-bit index so that vectors never
    // collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intc_priority_sel.sv
// ---------------------------------------------------------------------------
// intc_priority_sel
// Combinational priority selector. Scans the pending vector starting at
// 'start' and wrapping around, and reports the first set bit it finds.
// Ports:
//   pending [NUM_SRC-1:0] in  : requests eligible for selection
//   start   [IDX_W-1:0]   in  : index that has the highest priority
//   grant   [NUM_SRC-1:0] out : one-hot of the selected request
//   index   [IDX_W-1:0]   out : binary index of the selected request
//   valid                 out : at least one request is pending
// ---------------------------------------------------------------------------
module intc_priority_sel
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] pending,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // Walk the sources in priority order from 'start'; the first pending
    // one seen wins and later candidates are ignored once valid is set.
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = IDX_W'((int'(start) + k) % NUM_SRC);
            if (!valid && pending[cand]) begin
                valid       = 1'b1;
                index       = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Latches rising edges of device interrupt requests as pending, selects one
// by priority, presents it to the system register file as inta/idn and then
// blocks further interrupts until the handler's reti retires.
// Ports:
//   clk, reset             in  : clock, synchronous active-high reset
//   irqIn     [NUM_SRC-1:0] in  : level requests, rising edge sets pending
//   ieBit                  in  : interrupt enable (PCS[0])
//   intaReady              in  : pipeline can redirect this cycle
//   isReti                 in  : reti retiring this cycle
//   inta                   out : interrupt request to system register file
//   idn       [DBITS-1:0]  out : device number, valid while inta=1
//   irqAck    [NUM_SRC-1:0] out : one-cycle one-hot acceptance pulse
//   inService              out : handler running
//   pendingOut[NUM_SRC-1:0] out : pending vector
// Optional feature: define INTC_ROUND_ROBIN_EN for rotating priority that
// starts one past the most recently accepted source. Without it the lowest
// index always wins.
// ---------------------------------------------------------------------------
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int DBITS    = DEFAULT_DBITS,
    parameter int NUM_SRC  = 4,
    parameter int IDN_BASE = DEFAULT_IDN_BASE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irqIn,
    input  logic               ieBit,
    input  logic               intaReady,
    input  logic               isReti,
    output logic               inta,
    output logic [DBITS-1:0]   idn,
    output logic [NUM_SRC-1:0] irqAck,
    output logic               inService,
    output logic [NUM_SRC-1:0] pendingOut
);

    localparam int IDX_W = idx_width(NUM_SRC);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_SRC-1:0] sel_q, sel_d;
    logic [DBITS-1:0]   idn_q, idn_d;
    logic               inta_q, inta_d;
    logic               in_service_q, in_service_d;

    logic               accept;
    logic [NUM_SRC-1:0] sel_grant;
    logic [IDX_W-1:0]   sel_index;
    logic               sel_valid;
    logic [IDX_W-1:0]   start_idx;

    intc_priority_sel #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_sel (
        .pending (pending_q),
        .start   (start_idx),
        .grant   (sel_grant),
        .index   (sel_index),
        .valid   (sel_valid)
    );

`ifdef INTC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] sel_idx_q, sel_idx_d;

    // Rotating priority: the search begins just after the last accepted
    // source. The binary index of the latched selection is kept so the
    // pointer can be updated at acceptance time.
    always_comb begin
        last_grant_d = last_grant_q;
        sel_idx_d    = sel_idx_q;
        if (accept) begin
            last_grant_d = sel_idx_q;
        end
        if (state_q == IDLE && sel_valid) begin
            sel_idx_d = sel_index;
        end
        if (int'(last_grant_q) == NUM_SRC - 1) begin
            start_idx = '0;
        end else begin
            start_idx = last_grant_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= '0;
            sel_idx_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            sel_idx_q    <= sel_idx_d;
        end
    end
`else
    assign start_idx = '0;
`endif

    // Acceptance happens in the same cycle the pipeline and enable agree.
    // Reset suppresses it so a request interrupted by reset is never acked.
    // Pending bits clear on acceptance, but a fresh rising edge in the same
    // cycle is a new request and keeps the bit set.
    always_comb begin
        accept       = inta_q & ieBit & intaReady & ~reset;
        irqAck       = accept ? sel_q : '0;
        irq_prev_d   = irqIn;
        pending_d    = (pending_q & ~irqAck) | (irqIn & ~irq_prev_q);
        state_d      = state_q;
        sel_d        = sel_q;
        idn_d        = idn_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = REQ;
                    sel_d   = sel_grant;
                    idn_d   = DBITS'(IDN_BASE) + DBITS'(sel_index);
                end
            end
            REQ: begin
                if (accept) begin
                    state_d = SERVICE;
                end else if ((pending_q & sel_q) == '0) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (isReti) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        inta_d       = (state_d == REQ);
        in_service_d = (state_d == SERVICE);
    end

    // All controller state, including the registered outputs, is cleared
    // by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            irq_prev_q   <= '0;
            sel_q        <= '0;
            idn_q        <= '0;
            inta_q       <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            irq_prev_q   <= irq_prev_d;
            sel_q        <= sel_d;
            idn_q        <= idn_d;
            inta_q       <= inta_d;
            in_service_q <= in_service_d;
        end
    end

    assign inta       = inta_q;
    assign idn        = idn_q;
    assign inService  = in_service_q;
    assign pendingOut = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
// Directed bench for interrupt_controller (NUM_SRC=4, DBITS=32, IDN_BASE=0).
// Honors INTC_ROUND_ROBIN_EN for the simultaneous-request ordering.
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  irqIn;
    logic        ieBit;
    logic        intaReady;
    logic        isReti;
    logic        inta;
    logic [31:0] idn;
    logic [3:0]  irqAck;
    logic        inService;
    logic [3:0]  pendingOut;

    int checks;
    int errors;

`ifdef INTC_ROUND_ROBIN_EN
    localparam logic [31:0] FIRST_IDN  = 32'd3;
    localparam logic [3:0]  FIRST_OH   = 4'b1000;
    localparam logic [31:0] SECOND_IDN = 32'd1;
    localparam logic [3:0]  SECOND_OH  = 4'b0010;
`else
    localparam logic [31:0] FIRST_IDN  = 32'd1;
    localparam logic [3:0]  FIRST_OH   = 4'b0010;
    localparam logic [31:0] SECOND_IDN = 32'd3;
    localparam logic [3:0]  SECOND_OH  = 4'b1000;
`endif

    interrupt_controller #(
        .DBITS    (32),
        .NUM_SRC  (4),
        .IDN_BASE (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irqIn      (irqIn),
        .ieBit      (ieBit),
        .intaReady  (intaReady),
        .isReti     (isReti),
        .inta       (inta),
        .idn        (idn),
        .irqAck     (irqAck),
        .inService  (inService),
        .pendingOut (pendingOut)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the next cycle and drive that cycle's inputs shortly after
    // the rising edge, leaving settle time before outputs are sampled.
    task automatic applyStimulus(input logic rst, input logic [3:0] irq,
                                 input logic ie, input logic rdy,
                                 input logic reti);
        @(posedge clk);
        #1;
        reset     = rst;
        irqIn     = irq;
        ieBit     = ie;
        intaReady = rdy;
        isReti    = reti;
        #1;
    endtask

    // Compare every observable output against the hand-computed values for
    // the current cycle.
    task automatic checkOutput(input string tag, input logic expInta,
                               input logic [31:0] expIdn,
                               input logic [3:0] expAck,
                               input logic expInSvc,
                               input logic [3:0] expPend);
        checks++;
        assert (inta === expInta) else begin
            errors++;
            $error("[TB] FAIL %s inta got %0b expected %0b", tag, inta, expInta);
        end
        checks++;
        assert (idn === expIdn) else begin
            errors++;
            $error("[TB] FAIL %s idn got %0d expected %0d", tag, idn, expIdn);
        end
        checks++;
        assert (irqAck === expAck) else begin
            errors++;
            $error("[TB] FAIL %s irqAck got %b expected %b", tag, irqAck, expAck);
        end
        checks++;
        assert (inService === expInSvc) else begin
            errors++;
            $error("[TB] FAIL %s inService got %0b expected %0b", tag, inService, expInSvc);
        end
        checks++;
        assert (pendingOut === expPend) else begin
            errors++;
            $error("[TB] FAIL %s pendingOut got %b expected %b", tag, pendingOut, expPend);
        end
    endtask

    // Linear directed sequence; each step is one clock cycle.
    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        irqIn     = 4'b0000;
        ieBit     = 1'b0;
        intaReady = 1'b0;
        isReti    = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_c1", 1'b0, 32'd0, 4'b0000, 1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        checkOutput("reset_c2", 1'b0, 32'd0, 4'b0000, 1'b0, 4'b0000);

        $display("[TB] single request on source 2");
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        checkOutput("s2_edge", 1'b0, 32'd0, 4'b0000, 1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        checkOutput("s2_pend", 1'b0, 32'd0, 4'b0000, 1'b0, 4'b0100);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        checkOutput("s2_req", 1'b1, 32'd2, 4'b0100, 1'b0, 4'b0100);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        checkOutput("s2_svc", 1'b0, 32'd2, 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        checkOutput("s2_svc_hold", 1'b0, 32'd2, 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1, 1'b1);
        checkOutput("s2_reti", 1'b0, 32'd2, 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        checkOutput("s2_idle", 1'b0, 32'd2, 4'b0000, 1'b0, 4'b0000);

        $display("[TB] simultaneous requests on sources 1 and 3");
        applyStimulus(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0);
        checkOutput("dual_edge", 1'b0, 32'd2, 4'b0000, 1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0);
        checkOutput("dual_pend", 1'b0, 32'd2, 4'b0000, 1'b0, 4'b1010);
        applyStimulus(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0);
        checkOutput("dual_req1", 1'b1, FIRST_IDN, FIRST_OH, 1'b0, 4'b1010);
        applyStimulus(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0);
        checkOutput("dual_svc1", 1'b0, FIRST_IDN, 4'b0000, 1'b1, SECOND_OH);
        applyStimulus(1'b0, 4'b1010, 1'b1, 1'b1, 1'b1);
        checkOutput("dual_reti1", 1'b0, FIRST_IDN, 4'b0000, 1'b1, SECOND_OH);
        applyStimulus(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0);
        checkOutput("dual_idle1", 1'b0, FIRST_IDN, 4'b0000, 1'b0, SECOND_OH);
        applyStimulus(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0);
        checkOutput("dual_req2", 1'b1, SECOND_IDN, SECOND_OH, 1'b0, SECOND_OH);
        applyStimulus(1'b0, 4'b1010, 1'b1, 1'b1, 1'b0);
        checkOutput("dual_svc2", 1'b0, SECOND_IDN, 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
        checkOutput("dual_reti2", 1'b0, SECOND_IDN, 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        checkOutput("dual_idle2", 1'b0, SECOND_IDN, 4'b0000, 1'b0, 4'b0000);

        $display("[TB] enable held low while requesting");
        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0);
        checkOutput("ie_edge", 1'b0, SECOND_IDN, 4'b0000, 1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0);
        checkOutput("ie_pend", 1'b0, SECOND_IDN, 4'b0000, 1'b0, 4'b0100);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0);
            checkOutput("ie_wait", 1'b1, 32'd2, 4'b0000, 1'b0, 4'b0100);
        end
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        checkOutput("rdy_wait", 1'b1, 32'd2, 4'b0000, 1'b0, 4'b0100);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        checkOutput("ie_accept", 1'b1, 32'd2, 4'b0100, 1'b0, 4'b0100);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        checkOutput("ie_svc", 1'b0, 32'd2, 4'b0000, 1'b1, 4'b0000);

        $display("[TB] new edge during service");
        applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 1'b0);
        checkOutput("svc_edge", 1'b0, 32'd2, 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 1'b0);
        checkOutput("svc_pend", 1'b0, 32'd2, 4'b0000, 1'b1, 4'b0001);
        applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 1'b1);
        checkOutput("svc_reti", 1'b0, 32'd2, 4'b0000, 1'b1, 4'b0001);
        applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 1'b0);
        checkOutput("svc_idle", 1'b0, 32'd2, 4'b0000, 1'b0, 4'b0001);
        applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 1'b0);
        checkOutput("svc_req0", 1'b1, 32'd0, 4'b0001, 1'b0, 4'b0001);
        applyStimulus(1'b0, 4'b0101, 1'b1, 1'b1, 1'b0);
        checkOutput("svc_svc0", 1'b0, 32'd0, 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
        checkOutput("svc_reti0", 1'b0, 32'd0, 4'b0000, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        checkOutput("svc_idle0", 1'b0, 32'd0, 4'b0000, 1'b0, 4'b0000);

        $display("[TB] reset while requesting");
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_edge", 1'b0, 32'd0, 4'b0000, 1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_pend", 1'b0, 32'd0, 4'b0000, 1'b0, 4'b1010);
        applyStimulus(1'b0, 4'b1010, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_req", 1'b1, 32'd1, 4'b0000, 1'b0, 4'b1010);
        applyStimulus(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);
        checkOutput("rst_assert", 1'b1, 32'd1, 4'b0000, 1'b0, 4'b1010);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        checkOutput("rst_after", 1'b0, 32'd0, 4'b0000, 1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        checkOutput("rst_idle", 1'b0, 32'd0, 4'b0000, 1'b0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
